// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode encodings, FSM states
// and the opcode legality helper.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a command source and the
// ALU sequencer; slave is the sequencer side, master the command source.
interface alu_sequencer_if #(
    parameter int W   = 32,
    parameter int OPW = 3
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero;
    logic           rsp_illegal;
    logic           rsp_zchk_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal, rsp_zchk_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal, rsp_zchk_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issues registered commands to a combinational ALU, waits SETTLE cycles,
// captures result/zero flag and returns them with completion/error counters.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int OPW    = 3,
    parameter int SETTLE = 1,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.slave   bus,
    output logic [OPW-1:0]   alu_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_r,
    input  logic             alu_z,
    output logic [CNTW-1:0]  op_count,
    output logic [7:0]       err_count
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic            rsp_zchk_q, rsp_zchk_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            req_ready_c;
    logic            accept;

    // req_ready is forced low during reset even though the state already reads IDLE
    always_comb begin
        req_ready_c = 1'b0;
        case (state_q)
            IDLE:    req_ready_c = 1'b1;
            DONE:    req_ready_c = bus.rsp_ready;
            default: req_ready_c = 1'b0;
        endcase
        req_ready_c = req_ready_c & rst_n;
    end

    assign accept = bus.req_valid && req_ready_c;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        illegal_d     = illegal_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_zchk_d    = rsp_zchk_q;
        op_count_d    = op_count_q;
        err_count_d   = err_count_q;

        if (accept) begin
            alu_op_d  = bus.req_op;
            alu_a_d   = bus.req_a;
            alu_b_d   = bus.req_b;
            cnt_d     = SETTLE_C;
            illegal_d = !is_legal_op(bus.req_op);
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d    = alu_r;
                    rsp_zero_d    = alu_z;
                    rsp_zchk_d    = alu_z ^ (alu_r == '0);
                    rsp_illegal_d = illegal_q;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    if ((rsp_illegal_q || rsp_zchk_q) && (err_count_q != 8'hFF))
                        err_count_d = err_count_q + 8'd1;
                    state_d = accept ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            illegal_q     <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_zchk_q    <= 1'b0;
            op_count_q    <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            illegal_q     <= illegal_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_zchk_q    <= rsp_zchk_d;
            op_count_q    <= op_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = (state_q == DONE);
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_illegal  = rsp_illegal_q;
    assign bus.rsp_zchk_err = rsp_zchk_q;
    assign alu_op           = alu_op_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign op_count         = op_count_q;
    assign err_count        = err_count_q;

endmodule
